// File: rtl/uart_hex_pkg.sv
`default_nettype none
// ============================================================================
// Package     : uart_hex_pkg
// Description : Shared types, ASCII constants and the nibble-to-ASCII
//               encoder used by the UART hex text sender.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_hex_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_e;

  // ASCII code points used to build the text frame.
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Map one hex digit to its ASCII character; uppercase selects A-F vs a-f.
  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                 input logic       uppercase);
    logic [7:0] base;
    if (nibble < 4'd10) begin
      return ASCII_0 + {4'h0, nibble};
    end
    base = uppercase ? ASCII_UA : ASCII_LA;
    return base + {4'h0, nibble} - 8'd10;
  endfunction

endpackage : uart_hex_pkg
`default_nettype wire

// File: rtl/uart_hex_sender.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_sender
// Description : Captures a binary value on start and writes its hexadecimal
//               ASCII text (MS nibble first) into the UART TX FIFO, one byte
//               per accepted write, honouring tx_full back-pressure.
//               Optional feature macro: UART_HEX_SENDER_CRLF_EN appends a
//               CR/LF pair to every frame.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_hex_sender
  import uart_hex_pkg::*;
#(
  parameter int NIBBLES   = 4,
  parameter int UPPERCASE = 1
) (
  input  logic                   clk,
  input  logic                   rst,      // asynchronous, active-low
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   data,
  input  logic                   tx_full,
  output logic                   wr_uart,
  output logic [7:0]             w_data,
  output logic                   busy,
  output logic                   done
);

  // Frame length and index width; the counter must be able to hold L itself
  // because it advances once more on the final write.
`ifdef UART_HEX_SENDER_CRLF_EN
  localparam int FRAME_LEN = NIBBLES + 2;
`else
  localparam int FRAME_LEN = NIBBLES;
`endif
  localparam int IDX_W = $clog2(FRAME_LEN + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
  localparam logic             UC_SEL   = (UPPERCASE != 0);

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [4*NIBBLES-1:0]   data_q,  data_d;

  logic [3:0]             cur_nib;
  logic [7:0]             cur_byte;

  // State, byte index and captured value registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Select the byte addressed by the index: a hex digit of the captured
  // value (MS nibble at index 0), or the line terminator when enabled.
  always_comb begin
    cur_nib = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(NIBBLES - 1 - i)) begin
        cur_nib = data_q[4*i +: 4];
      end
    end
    cur_byte = nibble_to_ascii(cur_nib, UC_SEL);
`ifdef UART_HEX_SENDER_CRLF_EN
    if (idx_q == IDX_W'(NIBBLES)) begin
      cur_byte = ASCII_CR;
    end else if (idx_q == IDX_W'(NIBBLES + 1)) begin
      cur_byte = ASCII_LF;
    end
`endif
  end

  // Next-state logic and outputs; the FIFO write is gated directly by
  // tx_full so a full FIFO is never written.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wr_uart = 1'b0;
    w_data  = 8'h00;
    busy    = 1'b0;
    done    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEND;
          idx_d   = '0;
          data_d  = data;
        end
      end

      SEND: begin
        busy    = 1'b1;
        wr_uart = !tx_full;
        w_data  = cur_byte;
        if (!tx_full) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule : uart_hex_sender
`default_nettype wire
